alu_seq_arbiter: RTL and testbench

Sequencing controller that shares the single combinational 3-bit ALU (A, B, 3-bit ctrl → 6-bit LED/result word) between two requesters. It arbitrates round-robin, latches the winner's operands onto the ALU inputs, waits a programmable settle time, and captures the result. It then returns the result with the requester ID over a valid/ready response port. It sits between the top-level pin logic and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 11 +
 rtl/alu_seq_arbiter_rr_arb2.sv | 11 +
 rtl/alu_seq_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_seq_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the two-requester ALU sequencing controller.
package alu_seq_pkg;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   localparam int DEF_DW = 3;
   localparam int DEF_CW = 3;
   localparam int DEF_RW = 6;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/alu_seq_arbiter_rr_arb2.sv
// Two-way round-robin pick; the parent owns and updates last_grant.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant_vld,
   output logic       grant_id
);
   assign grant_vld = |valid;
   // On contention the requester that did not win last time goes first.
   assign grant_id  = (valid == 2'b11) ? ~last_grant : valid[1];
endmodule

// File: rtl/alu_seq_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrate, hold operands
// for SETTLE cycles, capture the result and return it over a valid/ready port.
module alu_seq_arbiter
   import alu_seq_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int CW     = DEF_CW,
   parameter int RW     = DEF_RW,
   parameter int SETTLE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic [CW-1:0] req0_op,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   input  logic [CW-1:0] req1_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [CW-1:0] alu_ctrl,
   input  logic [RW-1:0] alu_res,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [RW-1:0] rsp_data,
   output logic          busy
);
   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("alu_seq_arbiter: SETTLE must be in 1..15");
      end
   endgenerate

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic [CW-1:0] op_q, op_d;
   logic          rv_q, rv_d;
   logic          id_q, id_d;
   logic [RW-1:0] data_q, data_d;
   logic          busy_q, busy_d;

   logic grant_vld, grant_id, accept;

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_q),
      .grant_vld  (grant_vld),
      .grant_id   (grant_id)
   );

   // Readies stay low while rst is asserted so nothing is handed off during reset.
   assign req0_ready = !rst && (state_q == IDLE) && grant_vld && (grant_id == REQ0);
   assign req1_ready = !rst && (state_q == IDLE) && grant_vld && (grant_id == REQ1);
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      rv_d    = rv_q;
      id_d    = id_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = (grant_id == REQ1) ? req1_a  : req0_a;
               b_d     = (grant_id == REQ1) ? req1_b  : req0_b;
               op_d    = (grant_id == REQ1) ? req1_op : req0_op;
               id_d    = grant_id;
               last_d  = grant_id;
               cnt_d   = 4'(SETTLE);
               state_d = EXEC;
            end
         end
         EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               data_d  = alu_res;
               rv_d    = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rv_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         rv_q    <= 1'b0;
         id_q    <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rv_q    <= rv_d;
         id_q    <= id_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_ctrl  = op_q;
   assign rsp_valid = rv_q;
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Directed bench: two instances (SETTLE=1 and SETTLE=4) sharing stimulus,
// each with an ALU stub returning {alu_a, alu_b}.
module tb_alu_seq_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, v0, v1, rr;
   logic [2:0] a0, b0, op0, a1, b1, op1;

   logic       r0_1, r1_1, rv_1, id_1, bz_1;
   logic [2:0] aa_1, ab_1, ac_1;
   logic [5:0] res_1, d_1;
   logic       r0_4, r1_4, rv_4, id_4, bz_4;
   logic [2:0] aa_4, ab_4, ac_4;
   logic [5:0] res_4, d_4;

   assign res_1 = {aa_1, ab_1};
   assign res_4 = {aa_4, ab_4};

   alu_seq_arbiter #(.SETTLE(1)) u1 (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(r0_1), .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_valid(v1), .req1_ready(r1_1), .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .alu_a(aa_1), .alu_b(ab_1), .alu_ctrl(ac_1), .alu_res(res_1),
      .rsp_valid(rv_1), .rsp_ready(rr), .rsp_id(id_1), .rsp_data(d_1), .busy(bz_1));

   alu_seq_arbiter #(.SETTLE(4)) u4 (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(r0_4), .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_valid(v1), .req1_ready(r1_4), .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .alu_a(aa_4), .alu_b(ab_4), .alu_ctrl(ac_4), .alu_res(res_4),
      .rsp_valid(rv_4), .rsp_ready(rr), .rsp_id(id_4), .rsp_data(d_4), .busy(bz_4));

   typedef struct {
      logic       v0, v1;
      logic [2:0] a0, b0, op0, a1, b1, op1;
      logic       rr;
      logic       r0, r1, rv, id;
      logic [5:0] data;
      logic       busy;
      logic [2:0] ea, eb, ec;
   } vec_t;

   vec_t tv [22];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      v0 = 0; v1 = 0; rr = 1;
   endtask

   logic [31:0] act, exp;
   int n;
   logic seen;

   initial begin
      rst = 1; v0 = 1; v1 = 1; rr = 1;
      a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;

      // Reset held two cycles with both valids high
      for (int k = 0; k < 2; k++) begin
         step();
         chk($sformatf("reset%0d_u1", k), {r0_1, r1_1, rv_1, bz_1, aa_1, ab_1, ac_1, id_1, d_1},
             {4'b0000, 9'd0, 1'b0, 6'd0});
         chk($sformatf("reset%0d_u4", k), {r0_4, r1_4, rv_4, bz_4, aa_4, ab_4, ac_4},
             {4'b0000, 9'd0});
      end

      //         v0 v1 a0 b0 o0 a1 b1 o1 rr  r0 r1 rv id data busy ea eb ec
      tv[0]  = '{1, 0, 5, 2, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 0, 0, 0};
      tv[1]  = '{0, 0, 5, 2, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0,  1, 5, 2, 1};
      tv[2]  = '{1, 1, 5, 2, 1, 1, 3, 2, 1,  0, 0, 1, 0, 42, 1, 5, 2, 1};
      tv[3]  = '{1, 1, 5, 2, 1, 1, 3, 2, 1,  0, 1, 0, 0, 42, 0, 5, 2, 1};
      tv[4]  = '{0, 0, 5, 2, 1, 1, 3, 2, 1,  0, 0, 0, 1, 42, 1, 1, 3, 2};
      tv[5]  = '{0, 0, 5, 2, 1, 1, 3, 2, 1,  0, 0, 1, 1, 11, 1, 1, 3, 2};
      tv[6]  = '{1, 1, 6, 1, 3, 1, 3, 2, 1,  1, 0, 0, 1, 11, 0, 1, 3, 2};
      tv[7]  = '{0, 0, 6, 1, 3, 1, 3, 2, 1,  0, 0, 0, 0, 11, 1, 6, 1, 3};
      tv[8]  = '{0, 0, 6, 1, 3, 1, 3, 2, 1,  0, 0, 1, 0, 49, 1, 6, 1, 3};
      tv[9]  = '{1, 1, 6, 1, 3, 7, 4, 4, 1,  0, 1, 0, 0, 49, 0, 6, 1, 3};
      tv[10] = '{0, 0, 6, 1, 3, 7, 4, 4, 0,  0, 0, 0, 1, 49, 1, 7, 4, 4};
      for (int k = 11; k < 16; k++)
         tv[k] = '{1, 1, 6, 1, 3, 7, 4, 4, 0,  0, 0, 1, 1, 60, 1, 7, 4, 4};
      tv[16] = '{1, 1, 6, 1, 3, 7, 4, 4, 1,  0, 0, 1, 1, 60, 1, 7, 4, 4};
      tv[17] = '{0, 0, 6, 1, 3, 7, 4, 4, 1,  0, 0, 0, 1, 60, 0, 7, 4, 4};
      tv[18] = '{1, 1, 6, 1, 3, 7, 4, 4, 1,  1, 0, 0, 1, 60, 0, 7, 4, 4};
      tv[19] = '{0, 0, 6, 1, 3, 7, 4, 4, 1,  0, 0, 0, 0, 60, 1, 6, 1, 3};
      tv[20] = '{0, 0, 6, 1, 3, 7, 4, 4, 1,  0, 0, 1, 0, 49, 1, 6, 1, 3};
      tv[21] = '{0, 0, 6, 1, 3, 7, 4, 4, 1,  0, 0, 0, 0, 49, 0, 6, 1, 3};

      rst = 0;
      for (int i = 0; i < 22; i++) begin
         v0 = tv[i].v0; v1 = tv[i].v1; rr = tv[i].rr;
         a0 = tv[i].a0; b0 = tv[i].b0; op0 = tv[i].op0;
         a1 = tv[i].a1; b1 = tv[i].b1; op1 = tv[i].op1;
         #1;
         act = {9'd0, r0_1, r1_1, rv_1, id_1, d_1, bz_1, aa_1, ab_1, ac_1};
         exp = {9'd0, tv[i].r0, tv[i].r1, tv[i].rv, tv[i].id, tv[i].data, tv[i].busy,
                tv[i].ea, tv[i].eb, tv[i].ec};
         chk($sformatf("vec%0d", i), act, exp);
         step();
      end

      // SETTLE=4: response exactly 5 cycles after accept
      idle_in(); rst = 1; step(); rst = 0;
      v0 = 1; a0 = 7; b0 = 7; op0 = 0; #1;
      chk("s4_accept_ready", {r0_4, r1_4}, 2'b10);
      step(); v0 = 0; n = 1;
      chk("s4_busy", bz_4, 1'b1);
      while (!rv_4 && n < 20) begin step(); n++; end
      chk("s4_latency", n, 5);
      chk("s4_data", {rv_4, d_4, id_4}, {1'b1, 6'b111111, 1'b0});

      // Mid-op reset discards the in-flight result
      idle_in(); rst = 1; step(); rst = 0;
      v0 = 1; a0 = 3; b0 = 3; op0 = 2; #1;
      chk("mid_accept", r0_1, 1'b1);
      step(); v0 = 0;
      chk("mid_exec_busy", bz_1, 1'b1);
      rst = 1; step(); rst = 0;
      chk("mid_reset_vals", {rv_1, bz_1, aa_1, ab_1, ac_1}, 11'd0);
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         if (rv_1) seen = 1;
         step();
      end
      chk("mid_no_rsp", seen, 1'b0);
      v1 = 1; a1 = 1; b1 = 0; op1 = 5; #1;
      chk("mid_req1_ready", {r0_1, r1_1}, 2'b01);
      step(); v1 = 0; n = 1;
      while (!rv_1 && n < 20) begin step(); n++; end
      chk("mid_req1_latency", n, 2);
      chk("mid_req1_rsp", {rv_1, id_1, d_1}, {1'b1, 1'b1, 6'b001000});
      step();
      chk("mid_req1_idle", {rv_1, bz_1}, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
